frog_collision: RTL and testbench
=================================

# frog_collision

Per-frame collision and life-management block for the Froge game. It sits directly downstream of the truck position generator: it takes the eight truck coordinates and the frog coordinate, tests bounding-box overlap every `frame_clk`, and runs the frog life cycle (alive, dying, respawn, game over). Its outputs drive the frog controller (respawn) and the HUD/renderer (lives, death animation, game-over).

## Interface
Parameters:
- `TRUCK_W`, 48: truck box width, pixels.
- `TRUCK_H`, 32: truck box height, pixels.
- `FROG_W`, 32: frog box width and height, pixels.
- `LIVES_INIT`, 3: lives loaded on reset, range 1..7.
- `DEATH_FRAMES`, 30: frames spent in DYING.
- `GRACE_FRAMES`, 60: post-respawn invulnerability frames.

Ports:
- `frame_clk`  in  1  frame-rate clock; all state advances on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `frog_x`, `frog_y`  in  32 (int, signed)  frog top-left corner.
- `truck_x[8]`, `truck_y[8]`  in  32 each (int, signed)  truck top-left corners, index 0..7 = truck1..truck8.
- `hit_mask`  out  8  registered per-truck overlap result from the last edge.
- `lives`  out  3  remaining lives.
- `frog_dead`  out  1  high while in DYING.
- `death_frame`  out  5  DYING frame index, 0..DEATH_FRAMES-1; 0 outside DYING.
- `respawn`  out  1  one-frame pulse ordering the frog back to its start square.
- `invuln`  out  1  high while in GRACE.
- `game_over`  out  1  high in GAME_OVER.

## Operation
- Overlap for truck i uses signed 32-bit compares, all strict: `frog_x < truck_x+TRUCK_W`, `truck_x < frog_x+FROG_W`, `frog_y < truck_y+TRUCK_H`, `truck_y < frog_y+FROG_W`. Edge-touching is not a hit.
- Negative truck x (off-screen left, down to -48) is handled by the signed arithmetic. No clamping is applied.
- `hit_mask` registers all 8 overlap bits on every edge, in every state.
- States: ALIVE, DYING, RESPAWN, GRACE, GAME_OVER.
- ALIVE: if any overlap bit is set, go to DYING, decrement `lives`, and clear the death counter.
- DYING: the counter increments each edge. When the counter reaches DEATH_FRAMES-1:
  - `lives` == 0 → GAME_OVER.
  - otherwise → RESPAWN.
- RESPAWN: lasts exactly one frame with `respawn`=1, then goes to GRACE (or to ALIVE when grace is compiled out; see Configuration).
- GRACE: overlaps are ignored. A counter runs GRACE_FRAMES frames, then the state goes to ALIVE.
- GAME_OVER: terminal. Only `Reset` leaves it. Overlaps are ignored.
- `lives` never underflows. Decrement happens only on the ALIVE→DYING transition.
- Overlaps in DYING/RESPAWN/GRACE/GAME_OVER do not change `lives`.

## Timing
- Reset values: state=ALIVE, `lives`=LIVES_INIT, `hit_mask`=0, `frog_dead`=0, `death_frame`=0, `respawn`=0, `invuln`=0, `game_over`=0.
- Inputs are sampled at the rising edge. With an overlap present at edge N, the following are all visible after edge N (1-frame latency): `hit_mask` bit set, `frog_dead`=1, `lives` decremented.
- DYING lasts exactly DEATH_FRAMES frames. `respawn` is high for exactly one frame after that.
- `Reset` asserted mid-DYING or mid-GAME_OVER returns all outputs to reset values immediately, without waiting for an edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `FROGGER_GRACE_EN`.
- Defined: the GRACE state exists, `invuln` behaves as above, and RESPAWN→GRACE→ALIVE.
- Undefined: the GRACE state and counter are removed, RESPAWN→ALIVE, and `invuln` is tied 0. A truck overlapping the start square at respawn causes a hit on the first ALIVE edge.

## Structure
- Package `frog_pkg` holds:
  - the state enum `frog_state_t`;
  - `TRUCK_W`/`TRUCK_H`/`FROG_W` default constants;
  - the `NUM_TRUCKS`=8 constant.
- Sub-module `box_overlap`: purely combinational signed 4-compare test, instantiated NUM_TRUCKS times via generate.
- The FSM and counters live in `frog_collision`.

## Test plan
- Truck0 at (100,336), frog at (120,336) → after 1 edge: `hit_mask`=8'h01, `frog_dead`=1, `lives` 3→2.
- Truck0 at (100,336), frog at (148,336) (edge-touching) → `hit_mask`=0, state stays ALIVE.
- Truck4 at (-40,384), frog at (0,384) → hit on bit 4 (checks signed negative x).
- Single hit, overlap removed → `frog_dead` high for exactly 30 edges, then a 1-frame `respawn` pulse; with the macro defined, `invuln` high for 60 frames and overlap ignored throughout.
- Three consecutive hits from LIVES_INIT=3 → after the third DYING, `game_over`=1 and `lives`=0; further overlaps cause no change.
- `Reset` pulsed asynchronously mid-DYING (death_frame=12) → outputs return to reset values with no clock edge; `lives`=3.

Source files
------------

// File: rtl/frog_pkg.sv
// Shared types and defaults for the Froge collision/life block.
// The GRACE state is present only when FROGGER_GRACE_EN is defined.
package frog_pkg;

   localparam int NUM_TRUCKS  = 8;
   localparam int DEF_TRUCK_W = 48;
   localparam int DEF_TRUCK_H = 32;
   localparam int DEF_FROG_W  = 32;

   typedef enum logic [2:0] {
      ST_ALIVE     = 3'd0,
      ST_DYING     = 3'd1,
      ST_RESPAWN   = 3'd2,
`ifdef FROGGER_GRACE_EN
      ST_GRACE     = 3'd3,
`endif
      ST_GAME_OVER = 3'd4
   } frog_state_t;

endpackage

// File: rtl/box_overlap.sv
// Combinational bounding-box overlap test between the frog and one truck.
// All four compares are signed and strict, so edge contact is not a hit.
module box_overlap
   import frog_pkg::*;
#(
   parameter int BOX_W   = DEF_TRUCK_W,
   parameter int BOX_H   = DEF_TRUCK_H,
   parameter int FROG_SZ = DEF_FROG_W
)(
   input  logic signed [31:0] i_frog_x,
   input  logic signed [31:0] i_frog_y,
   input  logic signed [31:0] i_box_x,
   input  logic signed [31:0] i_box_y,
   output logic               o_hit
);

   logic signed [31:0] w_box_r;
   logic signed [31:0] w_box_b;
   logic signed [31:0] w_frog_r;
   logic signed [31:0] w_frog_b;

   assign w_box_r  = i_box_x  + 32'(BOX_W);
   assign w_box_b  = i_box_y  + 32'(BOX_H);
   assign w_frog_r = i_frog_x + 32'(FROG_SZ);
   assign w_frog_b = i_frog_y + 32'(FROG_SZ);

   assign o_hit = (i_frog_x < w_box_r) && (i_box_x < w_frog_r) &&
                  (i_frog_y < w_box_b) && (i_box_y < w_frog_b);

endmodule

// File: rtl/frog_collision.sv
// Per-frame truck collision test and frog life cycle (alive/dying/respawn/grace/game over).
// Define FROGGER_GRACE_EN to include the post-respawn invulnerability (GRACE) state.
module frog_collision
   import frog_pkg::*;
#(
   parameter int TRUCK_W      = DEF_TRUCK_W,
   parameter int TRUCK_H      = DEF_TRUCK_H,
   parameter int FROG_W       = DEF_FROG_W,
   parameter int LIVES_INIT   = 3,
   parameter int DEATH_FRAMES = 30,
   parameter int GRACE_FRAMES = 60
)(
   input  logic                  frame_clk,
   input  logic                  Reset,
   input  logic signed [31:0]    frog_x,
   input  logic signed [31:0]    frog_y,
   input  logic signed [31:0]    truck_x [NUM_TRUCKS],
   input  logic signed [31:0]    truck_y [NUM_TRUCKS],
   output logic [NUM_TRUCKS-1:0] hit_mask,
   output logic [2:0]            lives,
   output logic                  frog_dead,
   output logic [4:0]            death_frame,
   output logic                  respawn,
   output logic                  invuln,
   output logic                  game_over
);

   if (LIVES_INIT < 1 || LIVES_INIT > 7 || DEATH_FRAMES < 1 || DEATH_FRAMES > 32 ||
       GRACE_FRAMES < 1) begin : g_param_check
      $error("frog_collision: parameter out of range");
   end

   localparam logic [2:0] C_LIVES_INIT = 3'(LIVES_INIT);
   localparam logic [4:0] C_DEATH_LAST = 5'(DEATH_FRAMES - 1);

   logic [NUM_TRUCKS-1:0] w_overlap;
   frog_state_t           r_state;
   frog_state_t           w_state_nxt;
   logic [2:0]            r_lives;
   logic [2:0]            w_lives_nxt;
   logic [4:0]            r_death_cnt;
   logic [4:0]            w_death_nxt;
   logic [NUM_TRUCKS-1:0] r_hit_mask;

   for (genvar g = 0; g < NUM_TRUCKS; g++) begin : g_box
      box_overlap #(
         .BOX_W   (TRUCK_W),
         .BOX_H   (TRUCK_H),
         .FROG_SZ (FROG_W)
      ) u_box (
         .i_frog_x (frog_x),
         .i_frog_y (frog_y),
         .i_box_x  (truck_x[g]),
         .i_box_y  (truck_y[g]),
         .o_hit    (w_overlap[g])
      );
   end

`ifdef FROGGER_GRACE_EN
   localparam int unsigned GCW = ($clog2(GRACE_FRAMES) < 1) ? 1 : $clog2(GRACE_FRAMES);
   localparam logic [GCW-1:0] C_GRACE_LAST = GCW'(GRACE_FRAMES - 1);

   logic [GCW-1:0] r_grace_cnt;
   logic [GCW-1:0] w_grace_nxt;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_lives_nxt = r_lives;
      w_death_nxt = '0;
`ifdef FROGGER_GRACE_EN
      w_grace_nxt = '0;
`endif
      case (r_state)
         ST_ALIVE: begin
            // The hit is taken from the live overlap so the death shows one frame after contact.
            if (|w_overlap) begin
               w_state_nxt = ST_DYING;
               if (r_lives != '0) w_lives_nxt = r_lives - 3'd1;
            end
         end
         ST_DYING: begin
            if (r_death_cnt == C_DEATH_LAST) begin
               w_state_nxt = (r_lives == '0) ? ST_GAME_OVER : ST_RESPAWN;
            end else begin
               w_death_nxt = r_death_cnt + 5'd1;
            end
         end
         ST_RESPAWN: begin
`ifdef FROGGER_GRACE_EN
            w_state_nxt = ST_GRACE;
`else
            w_state_nxt = ST_ALIVE;
`endif
         end
`ifdef FROGGER_GRACE_EN
         ST_GRACE: begin
            if (r_grace_cnt == C_GRACE_LAST) begin
               w_state_nxt = ST_ALIVE;
            end else begin
               w_grace_nxt = r_grace_cnt + 1'b1;
            end
         end
`endif
         ST_GAME_OVER: begin
            w_state_nxt = ST_GAME_OVER;
         end
         default: begin
            w_state_nxt = ST_ALIVE;
         end
      endcase
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= ST_ALIVE;
         r_lives     <= C_LIVES_INIT;
         r_death_cnt <= '0;
         r_hit_mask  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_lives     <= w_lives_nxt;
         r_death_cnt <= w_death_nxt;
         r_hit_mask  <= w_overlap;
      end
   end

`ifdef FROGGER_GRACE_EN
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_grace_cnt <= '0;
      end else begin
         r_grace_cnt <= w_grace_nxt;
      end
   end

   assign invuln = (r_state == ST_GRACE);
`else
   assign invuln = 1'b0;
`endif

   assign hit_mask    = r_hit_mask;
   assign lives       = r_lives;
   assign frog_dead   = (r_state == ST_DYING);
   assign death_frame = r_death_cnt;
   assign respawn     = (r_state == ST_RESPAWN);
   assign game_over   = (r_state == ST_GAME_OVER);

endmodule

// File: tb/tb_frog_collision.sv
// Directed bench for frog_collision: timeline model checked every frame plus literal spot checks.
// Honours FROGGER_GRACE_EN the same way as the design.
module tb_frog_collision;

   localparam int D = 30;
`ifdef FROGGER_GRACE_EN
   localparam int G = 60;
`else
   localparam int G = 0;
`endif

   logic               frame_clk;
   logic               Reset;
   logic signed [31:0] frog_x, frog_y;
   logic signed [31:0] truck_x [8];
   logic signed [31:0] truck_y [8];
   logic [7:0]         hit_mask;
   logic [2:0]         lives;
   logic               frog_dead;
   logic [4:0]         death_frame;
   logic               respawn;
   logic               invuln;
   logic               game_over;

   frog_collision dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .frog_x      (frog_x),
      .frog_y      (frog_y),
      .truck_x     (truck_x),
      .truck_y     (truck_y),
      .hit_mask    (hit_mask),
      .lives       (lives),
      .frog_dead   (frog_dead),
      .death_frame (death_frame),
      .respawn     (respawn),
      .invuln      (invuln),
      .game_over   (game_over)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Model: time since the last hit (m_k) drives every phase of the life cycle.
   bit       m_busy;
   bit       m_over;
   int       m_k;
   int       m_lives;
   bit [7:0] m_mask;

   function automatic bit box_hit(longint fx, longint fy, longint tx, longint ty);
      return (fx < tx + 48) && (tx < fx + 32) && (fy < ty + 32) && (ty < fy + 32);
   endfunction

   task automatic model_reset();
      m_busy  = 0;
      m_over  = 0;
      m_k     = 0;
      m_lives = 3;
      m_mask  = '0;
   endtask

   task automatic model_step();
      bit [7:0] mask;
      for (int i = 0; i < 8; i++) mask[i] = box_hit(frog_x, frog_y, truck_x[i], truck_y[i]);
      m_mask = mask;
      if (!m_over) begin
         if (!m_busy) begin
            if (mask != 0) begin
               m_busy = 1;
               m_k    = 0;
               if (m_lives > 0) m_lives--;
            end
         end else begin
            m_k++;
            if (m_k == D && m_lives == 0) begin
               m_over = 1;
               m_busy = 0;
            end else if (m_k > D + G) begin
               m_busy = 0;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge frame_clk);
      if (!Reset) model_step();
   end

   initial forever begin
      @(negedge frame_clk);
      chk("cyc_hit_mask", hit_mask, m_mask);
      chk("cyc_lives", lives, m_lives);
      chk("cyc_frog_dead", frog_dead, m_busy && m_k < D);
      chk("cyc_death_frame", death_frame, (m_busy && m_k < D) ? m_k : 0);
      chk("cyc_respawn", respawn, m_busy && m_k == D);
      chk("cyc_invuln", invuln, m_busy && m_k > D);
      chk("cyc_game_over", game_over, m_over);
   end

   task automatic tick();
      @(posedge frame_clk);
      #2;
   endtask

   task automatic park(input int i);
      truck_x[i] = 600;
      truck_y[i] = i * 40;
   endtask

   task automatic wait_dying(output int n);
      n = 0;
      while (frog_dead && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_recover(output int n);
      n = 0;
      while ((respawn || invuln) && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_lives"}, lives, 3);
      chk({tag, "_mask"}, hit_mask, 0);
      chk({tag, "_dead"}, frog_dead, 0);
      chk({tag, "_dframe"}, death_frame, 0);
      chk({tag, "_respawn"}, respawn, 0);
      chk({tag, "_invuln"}, invuln, 0);
      chk({tag, "_gameover"}, game_over, 0);
   endtask

   initial begin
      int n;
      Reset  = 1'b0;
      frog_x = 300;
      frog_y = 440;
      for (int i = 0; i < 8; i++) park(i);
      model_reset();
      #1 Reset = 1'b1;
      tick();
      tick();
      chk_reset_vals("rst");
      Reset = 1'b0;

      // edge-touching is not a hit
      truck_x[0] = 100; truck_y[0] = 336;
      frog_x = 148;     frog_y = 336;
      tick();
      chk("touch_mask", hit_mask, 0);
      chk("touch_dead", frog_dead, 0);
      chk("touch_lives", lives, 3);
      tick();

      // first hit and full recovery
      frog_x = 120;
      tick();
      chk("hit1_mask", hit_mask, 8'h01);
      chk("hit1_dead", frog_dead, 1);
      chk("hit1_lives", lives, 2);
      park(0);
      wait_dying(n);
      chk("hit1_dying_len", n, 30);
      chk("hit1_respawn_on", respawn, 1);
`ifdef FROGGER_GRACE_EN
      truck_x[0] = 100; truck_y[0] = 336;
`endif
      tick();
      chk("hit1_respawn_off", respawn, 0);
      n = 0;
      while (invuln && n < 200) begin
         tick();
         n++;
         if (n == 40) park(0);
      end
      chk("grace_len", n, G);
      chk("grace_lives", lives, 2);
      park(0);
      tick();

      // negative truck x
      frog_x = 0; frog_y = 384;
      truck_x[4] = -40; truck_y[4] = 384;
      tick();
      chk("neg_mask", hit_mask, 8'h10);
      chk("neg_lives", lives, 1);
      park(4);
      wait_dying(n);
      chk("neg_dying_len", n, 30);
      wait_recover(n);
      chk("neg_recover_len", n, 1 + G);
      tick();

      // last life: game over, then overlaps are ignored
      truck_x[7] = 10; truck_y[7] = 380;
      tick();
      chk("last_lives", lives, 0);
      chk("last_dead", frog_dead, 1);
      wait_dying(n);
      chk("last_dying_len", n, 30);
      chk("go_flag", game_over, 1);
      chk("go_respawn", respawn, 0);
      repeat (10) tick();
      chk("go_hold", game_over, 1);
      chk("go_hold_lives", lives, 0);
      chk("go_mask", hit_mask, 8'h80);

      // asynchronous reset mid-DYING
      park(7);
      Reset = 1'b1;
      model_reset();
      tick();
      Reset = 1'b0;
      truck_x[0] = 100; truck_y[0] = 336;
      frog_x = 120;     frog_y = 336;
      tick();
      chk("ar_lives", lives, 2);
      repeat (12) tick();
      chk("ar_dframe", death_frame, 12);
      #1;
      Reset = 1'b1;
      model_reset();
      #1;
      chk_reset_vals("ar");
      tick();
      park(0);
      Reset = 1'b0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
